bp_be_scoreboard_mc: RTL and testbench
======================================

# bp_be_scoreboard_mc

Multi-port, counter-based register scoreboard for the backend checker; generalised successor of the single-bit integer/FP scoreboards. Tracks in-flight long-latency writes per architectural register with saturating counters, so multiple outstanding writes to one register are legal. Accepts several score and clear ports per cycle and reports RAW/WAW matches for an arbitrary number of source operands. Instantiated once per register file, integer and FP, inside the hazard detector.

## Interface
Parameters:
- num_regs_p, 32, architectural registers tracked; reg_addr_width = $clog2(num_regs_p)
- num_rs_p, 3, source operands checked per cycle
- num_score_p, 1, score (allocate) ports
- num_clear_p, 2, clear (writeback) ports
- cnt_width_p, 2, per-register counter width; max in-flight = 2^cnt_width_p-1
- zero_reg_p, 1, 1: register 0 is hardwired and never scored (integer RF); 0: all registers tracked (FP RF)

Ports:
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  drop all pending entries
- score_v_i  in  num_score_p  per-port score valid
- score_rd_i  in  num_score_p*reg_addr_width  register to score, port 0 in LSBs
- clear_v_i  in  num_clear_p  per-port clear valid
- clear_rd_i  in  num_clear_p*reg_addr_width  register to clear
- check_rs_i  in  num_rs_p*reg_addr_width  source addresses of issuing instruction
- check_rd_i  in  reg_addr_width  destination of issuing instruction
- rs_match_o  out  num_rs_p  source has pending write
- rd_match_o  out  1  destination has pending write
- rd_full_o  out  1  destination counter at max; scoring it must stall
- busy_o  out  1  any counter nonzero
- error_o  out  1  sticky overflow/underflow flag

## Operation
- State: num_regs_p counters cnt[r], cnt_width_p bits; one sticky error bit.
- Per cycle, per register r: inc = number of score ports with score_v_i & score_rd==r; dec = number of clear ports with clear_v_i & clear_rd==r. Next = cnt[r] + inc - dec computed at cnt_width_p+$clog2(num_score_p+num_clear_p)+1 bits, signed.
- Next > max: cnt holds max, error set. Next < 0: cnt holds 0, error set. Otherwise cnt = next.
- zero_reg_p=1: register 0 ignores score and clear; rs/rd matches on address 0 always 0; never sets error.
- flush_i: all counters 0 next cycle; concurrent scores and clears ignored; error not cleared.
- rs_match_o[i] = cnt[check_rs[i]] != 0 (see Configuration). rd_match_o = cnt[check_rd] != 0. rd_full_o = cnt[check_rd] == max. busy_o = OR of all (cnt != 0).
- error_o cleared only by reset.

## Timing
- Reset (reset_n_i low, asynchronous): all counters 0, error 0; outputs rs_match_o=0, rd_match_o=0, rd_full_o=0, busy_o=0, error_o=0. Release is synchronous to clk_i by the integrator.
- Score/clear take effect at the next rising edge; outputs are combinational from registered counters, so a score in cycle N is visible in cycle N+1.
- Simultaneous score and clear of the same register in one cycle: net change, no transient; e.g. cnt=1, one score + one clear -> cnt=1, no error.
- Two score ports naming the same register: both counted.
- Reset asserted mid-cycle: state cleared immediately regardless of flush/score/clear.

## Configuration
- BP_BE_SCOREBOARD_CLEAR_BYPASS_EN defined: rs_match_o[i] and rd_match_o are computed against cnt - (same-cycle clears of that register), saturated at 0, so an instruction whose last pending write is retiring this cycle sees no match and issues one cycle earlier. rd_full_o and busy_o unaffected.
- Not defined: matches use registered counters only; one-cycle-later issue; no path from clear_* to match outputs.

## Test plan
- Reset: drive reset_n_i low with counters nonzero -> all outputs 0 immediately, error_o=0 after release.
- Score x5 in cycle 0, check_rs={5,6,0} in cycle 1 -> rs_match_o=3'b001; clear x5 in cycle 1 -> cycle 2 rs_match_o=0, busy_o=0.
- cnt_width_p=2: score x7 three times -> rd_full_o=1 with check_rd=7; fourth score -> cnt stays 3, error_o=1 sticky.
- Clear x9 with cnt=0 -> error_o=1, cnt[9]=0; score x0 with zero_reg_p=1 -> rd_match_o=0 for check_rd=0, no error.
- Scores on x3 in ports 0 and 1 plus clear x3 same cycle from cnt=1 -> cnt=2; then flush_i with concurrent score x4 -> busy_o=0 next cycle.
- With BP_BE_SCOREBOARD_CLEAR_BYPASS_EN: cnt[12]=1, check_rs[0]=12, clear x12 same cycle -> rs_match_o[0]=0 that cycle; without macro -> 1 that cycle, 0 next.

Source files
------------

// File: rtl/bp_be_scoreboard_mc.sv
// rtl/bp_be_scoreboard_mc.sv - multi-port counter-based register scoreboard (RAW/WAW tracking)
// Optional same-cycle clear bypass on match outputs: BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
module bp_be_scoreboard_mc #(
  parameter int num_regs_p  = 32,
  parameter int num_rs_p    = 3,
  parameter int num_score_p = 1,
  parameter int num_clear_p = 2,
  parameter int cnt_width_p = 2,
  parameter int zero_reg_p  = 1,
  localparam int reg_addr_width = $clog2(num_regs_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  flush_i,
  input  logic [num_score_p-1:0]                score_v_i,
  input  logic [num_score_p*reg_addr_width-1:0] score_rd_i,
  input  logic [num_clear_p-1:0]                clear_v_i,
  input  logic [num_clear_p*reg_addr_width-1:0] clear_rd_i,
  input  logic [num_rs_p*reg_addr_width-1:0]    check_rs_i,
  input  logic [reg_addr_width-1:0]             check_rd_i,
  output logic [num_rs_p-1:0]                   rs_match_o,
  output logic                                  rd_match_o,
  output logic                                  rd_full_o,
  output logic                                  busy_o,
  output logic                                  error_o
);

  localparam int sum_w = cnt_width_p + $clog2(num_score_p + num_clear_p) + 1;
  localparam logic signed [sum_w-1:0] one_s = sum_w'(1);
  localparam logic signed [sum_w-1:0] max_s = sum_w'((1 << cnt_width_p) - 1);
  localparam logic [cnt_width_p-1:0]  cnt_max = '1;

  logic [cnt_width_p-1:0] cnt_r [num_regs_p];
  logic [cnt_width_p-1:0] cnt_n [num_regs_p];
  logic                   err_r;
  logic                   ovf;
  logic signed [sum_w-1:0] acc;

  // Net score/clear effect per register, evaluated wide enough that no
  // combination of ports can wrap before saturation is applied.
  always_comb begin
    ovf = 1'b0;
    acc = '0;
    for (int r = 0; r < num_regs_p; r++) begin
      acc = $signed({{(sum_w-cnt_width_p){1'b0}}, cnt_r[r]});
      for (int p = 0; p < num_score_p; p++)
        if (score_v_i[p] && score_rd_i[p*reg_addr_width +: reg_addr_width] == reg_addr_width'(r))
          acc = acc + one_s;
      for (int p = 0; p < num_clear_p; p++)
        if (clear_v_i[p] && clear_rd_i[p*reg_addr_width +: reg_addr_width] == reg_addr_width'(r))
          acc = acc - one_s;
      if (zero_reg_p != 0 && r == 0) begin
        cnt_n[r] = '0;
      end else if (acc[sum_w-1]) begin
        cnt_n[r] = '0;
        ovf      = 1'b1;
      end else if (acc > max_s) begin
        cnt_n[r] = cnt_max;
        ovf      = 1'b1;
      end else begin
        cnt_n[r] = acc[cnt_width_p-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < num_regs_p; r++) cnt_r[r] <= '0;
      err_r <= 1'b0;
    end else if (flush_i) begin
      for (int r = 0; r < num_regs_p; r++) cnt_r[r] <= '0;
    end else begin
      for (int r = 0; r < num_regs_p; r++) cnt_r[r] <= cnt_n[r];
      err_r <= err_r | ovf;
    end
  end

  function automatic logic [cnt_width_p-1:0] cnt_at(input logic [reg_addr_width-1:0] a,
                                                    input logic [cnt_width_p-1:0] c);
    return (int'(a) < num_regs_p) ? c : '0;
  endfunction

`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
  localparam int cmp_w = cnt_width_p + $clog2(num_clear_p + 1);

  // Pending after this cycle's retirements: cnt - clears > 0, i.e. cnt > clears.
  function automatic logic pending(input logic [reg_addr_width-1:0] a,
                                   input logic [cnt_width_p-1:0] c,
                                   input logic [num_clear_p-1:0] cv,
                                   input logic [num_clear_p*reg_addr_width-1:0] crd);
    logic [cmp_w-1:0] clr;
    clr = '0;
    for (int p = 0; p < num_clear_p; p++)
      if (cv[p] && crd[p*reg_addr_width +: reg_addr_width] == a)
        clr = clr + cmp_w'(1);
    return cmp_w'(c) > clr;
  endfunction

  always_comb begin
    rs_match_o = '0;
    for (int i = 0; i < num_rs_p; i++)
      rs_match_o[i] = pending(check_rs_i[i*reg_addr_width +: reg_addr_width],
                              cnt_at(check_rs_i[i*reg_addr_width +: reg_addr_width],
                                     cnt_r[check_rs_i[i*reg_addr_width +: reg_addr_width]]),
                              clear_v_i, clear_rd_i);
    rd_match_o = pending(check_rd_i, cnt_at(check_rd_i, cnt_r[check_rd_i]), clear_v_i, clear_rd_i);
  end
`else
  always_comb begin
    rs_match_o = '0;
    for (int i = 0; i < num_rs_p; i++)
      rs_match_o[i] = cnt_at(check_rs_i[i*reg_addr_width +: reg_addr_width],
                             cnt_r[check_rs_i[i*reg_addr_width +: reg_addr_width]]) != '0;
    rd_match_o = cnt_at(check_rd_i, cnt_r[check_rd_i]) != '0;
  end
`endif

  always_comb begin
    busy_o = 1'b0;
    for (int r = 0; r < num_regs_p; r++) busy_o = busy_o | (cnt_r[r] != '0);
  end

  assign rd_full_o = cnt_at(check_rd_i, cnt_r[check_rd_i]) == cnt_max;
  assign error_o   = err_r;

endmodule

// File: tb/tb_bp_be_scoreboard_mc.sv
// tb/tb_bp_be_scoreboard_mc.sv - randomized self-checking bench for bp_be_scoreboard_mc
module tb_bp_be_scoreboard_mc;

  localparam int NR = 32, NRS = 3, NS = 2, NC = 2, AW = 5, MAXC = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic [NS-1:0]     score_v;
  logic [NS*AW-1:0]  score_rd;
  logic [NC-1:0]     clear_v;
  logic [NC*AW-1:0]  clear_rd;
  logic [NRS*AW-1:0] check_rs;
  logic [AW-1:0]     check_rd;
  logic [NRS-1:0]    rs_match;
  logic rd_match, rd_full, busy, error;

  int n_checks = 0;
  int n_errors = 0;
  int model_cnt [NR];
  bit model_err;

  always #5 clk = ~clk;

  bp_be_scoreboard_mc #(
    .num_regs_p(NR), .num_rs_p(NRS), .num_score_p(NS), .num_clear_p(NC),
    .cnt_width_p(2), .zero_reg_p(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .score_v_i(score_v), .score_rd_i(score_rd),
    .clear_v_i(clear_v), .clear_rd_i(clear_rd),
    .check_rs_i(check_rs), .check_rd_i(check_rd),
    .rs_match_o(rs_match), .rd_match_o(rd_match), .rd_full_o(rd_full),
    .busy_o(busy), .error_o(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 0; score_v = '0; score_rd = '0; clear_v = '0; clear_rd = '0;
    check_rs = '0; check_rd = '0;
  endtask

  function automatic int clears_of(int a);
    int n = 0;
    for (int p = 0; p < NC; p++) if (clear_v[p] && int'(clear_rd[p*AW +: AW]) == a) n++;
    return n;
  endfunction

  function automatic bit exp_match(int a);
    int view = model_cnt[a];
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
    view = view - clears_of(a);
    if (view < 0) view = 0;
`endif
    return view != 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) model_cnt[r] = 0;
    model_err = 0;
  endtask

  task automatic model_update();
    if (flush) begin
      for (int r = 0; r < NR; r++) model_cnt[r] = 0;
      return;
    end
    for (int r = 1; r < NR; r++) begin
      int n = model_cnt[r] - clears_of(r);
      for (int p = 0; p < NS; p++) if (score_v[p] && int'(score_rd[p*AW +: AW]) == r) n++;
      if (n > MAXC) begin n = MAXC; model_err = 1; end
      else if (n < 0) begin n = 0; model_err = 1; end
      model_cnt[r] = n;
    end
  endtask

  task automatic check_all();
    logic [NRS-1:0] ers;
    bit eb = 0;
    for (int i = 0; i < NRS; i++) ers[i] = exp_match(int'(check_rs[i*AW +: AW]));
    for (int r = 0; r < NR; r++) if (model_cnt[r] != 0) eb = 1;
    check("rs_match", 32'(rs_match), 32'(ers));
    check("rd_match", 32'(rd_match), 32'(exp_match(int'(check_rd))));
    check("rd_full", 32'(rd_full), 32'(model_cnt[check_rd] == MAXC));
    check("busy", 32'(busy), 32'(eb));
    check("error", 32'(error), 32'(model_err));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    check("rst_rs_match", 32'(rs_match), 0);
    check("rst_rd_match", 32'(rd_match), 0);
    check("rst_rd_full", 32'(rd_full), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_error", 32'(error), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    idle();
  endtask

  task automatic score1(int r);
    score_v = 2'b01; score_rd[4:0] = AW'(r);
  endtask

  task automatic clear1(int r);
    clear_v = 2'b01; clear_rd[4:0] = AW'(r);
  endtask

  initial begin
    idle();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    @(negedge clk);
    reset_n = 1;

    score1(5); step();
    check_rs = {5'd0, 5'd6, 5'd5}; clear1(5);
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
    #1 check("tp_rs_x5", 32'(rs_match), 32'b000);
`else
    #1 check("tp_rs_x5", 32'(rs_match), 32'b001);
`endif
    step();
    #1 check("tp_busy_after_clear", 32'(busy), 0);

    repeat (3) begin score1(7); step(); end
    check_rd = 5'd7;
    #1 check("tp_full_x7", 32'(rd_full), 1);
    check("tp_no_err_x7", 32'(error), 0);
    score1(7); step();
    check_rd = 5'd7;
    #1 check("tp_ovf_err", 32'(error), 1);
    check("tp_still_full", 32'(rd_full), 1);
    step();
    #1 check("tp_err_sticky", 32'(error), 1);
    do_reset();

    clear1(9); step();
    check_rd = 5'd9;
    #1 check("tp_udf_err", 32'(error), 1);
    check("tp_x9_zero", 32'(rd_match), 0);
    do_reset();

    score1(0); step();
    check_rd = 5'd0; check_rs = '0;
    #1 check("tp_x0_rd_match", 32'(rd_match), 0);
    check("tp_x0_no_err", 32'(error), 0);
    check("tp_x0_not_busy", 32'(busy), 0);
    do_reset();

    score1(3); step();
    score_v = 2'b11; score_rd = {5'd3, 5'd3}; clear1(3); step();
    check_rd = 5'd3;
    #1 check("tp_x3_match", 32'(rd_match), 1);
    check("tp_x3_not_full", 32'(rd_full), 0);
    check("tp_x3_no_err", 32'(error), 0);
    flush = 1; score1(4); step();
    #1 check("tp_flush_busy", 32'(busy), 0);
    check("tp_flush_no_err", 32'(error), 0);
    do_reset();

    score1(12); step();
    check_rs[4:0] = 5'd12; clear1(12);
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
    #1 check("tp_bypass_same", 32'(rs_match[0]), 0);
`else
    #1 check("tp_bypass_same", 32'(rs_match[0]), 1);
`endif
    step();
    check_rs[4:0] = 5'd12;
    #1 check("tp_bypass_next", 32'(rs_match[0]), 0);
    step();

    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 149) do_reset();
      score_v  = NS'($urandom_range(0, 3));
      clear_v  = NC'($urandom_range(0, 3));
      for (int p = 0; p < NS; p++) score_rd[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int p = 0; p < NC; p++) clear_rd[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int i = 0; i < NRS; i++) check_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      check_rd = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
